res_to_code: RTL and testbench

RES_TO_CODE -- requirements
Module: res_to_code

---
 rtl/res_pkg.sv | 23 ++
 rtl/seq_divider.sv | 79 +++++++
 rtl/res_to_code.sv | 113 +++++++++++
 tb/tb_res_to_code.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/res_pkg.sv
// res_pkg: shared constants and FSM state type for the resistance-to-ADC-code
// converter.
//   R_REF_OHMS  default reference resistor of the divider (ohms)
//   A1_W/RX_W   operand widths (full-scale code, target resistance)
//   DEN_W       width of R_REF + rx
//   DIVIDEND_W  width of the exact product a1 * rx
package res_pkg;

  localparam int A1_W       = 12;
  localparam int RX_W       = 11;
  localparam int DEN_W      = 14;
  localparam int DIVIDEND_W = 23;

  localparam logic [DEN_W-1:0] R_REF_OHMS = 14'd10_000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring binary divider, one quotient bit per clock, MSB first.
//   clk, rst  clock and synchronous active-high reset
//   start_i   clear remainder/quotient and begin NW steps (dividend/divisor
//             must stay stable on num_i/den_i while running)
//   num_i     dividend
//   den_i     divisor (nonzero)
//   done_o    high in the cycle whose closing edge performs the last step
//   quot_o    low QW bits of the quotient including this cycle's step, so it
//             is the final quotient while done_o is high
module seq_divider #(
  parameter int NW = 23,
  parameter int DW = 14,
  parameter int QW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [NW-1:0] num_i,
  input  logic [DW-1:0] den_i,
  output logic          done_o,
  output logic [QW-1:0] quot_o
);

  localparam int CW = $clog2(NW);

  // One bit wider than the divisor: the shifted partial remainder is below
  // 2*den, so the compare and subtract never overflow.
  logic [DW:0]   rem_q, rem_d, rem_sh;
  logic [NW-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    rem_d  = rem_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_o = 1'b0;
    rem_sh = '0;
    if (start_i) begin
      rem_d = '0;
      q_d   = '0;
      cnt_d = CW'(NW - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_sh = (DW+1)'({rem_q, num_i[cnt_q]});
      if (rem_sh >= {1'b0, den_i}) begin
        rem_d      = rem_sh - {1'b0, den_i};
        q_d[cnt_q] = 1'b1;
      end else begin
        rem_d      = rem_sh;
        q_d[cnt_q] = 1'b0;
      end
      if (cnt_q == '0) begin
        run_d  = 1'b0;
        done_o = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  assign quot_o = q_d[QW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/res_to_code.sv
// res_to_code: converts a target resistance rx into the ADC code expected
// from a divider against R_REF: a2 = floor(a1 * rx / (R_REF + rx)).
// Fixed latency: start accepted at edge N gives done during the cycle after
// edge N+24.
//   clk, rst  clock and synchronous active-high reset
//   start     conversion request, sampled only in IDLE
//   a1, rx    full-scale code and resistance, captured on acceptance
//   busy      high from acceptance until DONE is left
//   done      one-cycle pulse, a2 valid while high
//   a2        result, held until the next conversion completes
//
// state  | meaning
// IDLE   | waiting for start
// MUL    | form product a1*rx and divisor R_REF+rx, kick the divider
// DIV    | divider running, 23 steps
// DONE   | a2 updated, done pulse
module res_to_code
  import res_pkg::*;
#(
  parameter logic [DEN_W-1:0] R_REF = R_REF_OHMS,
  parameter int               NUM_W = DIVIDEND_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [A1_W-1:0] a1,
  input  logic [RX_W-1:0] rx,
  output logic            busy,
  output logic            done,
  output logic [A1_W-1:0] a2
);

  state_e             state_q, state_d;
  logic [A1_W-1:0]    a1_q, a1_d;
  logic [RX_W-1:0]    rx_q, rx_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [DEN_W-1:0]   den_q, den_d;
  logic [A1_W-1:0]    a2_q, a2_d;
  logic               div_start;
  logic               div_done;
  logic [A1_W-1:0]    div_quot;

  always_comb begin
    state_d   = state_q;
    a1_d      = a1_q;
    rx_d      = rx_q;
    num_d     = num_q;
    den_d     = den_q;
    a2_d      = a2_q;
    div_start = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a1_d    = a1;
          rx_d    = rx;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        num_d     = NUM_W'(a1_q) * NUM_W'(rx_q);
        den_d     = R_REF + DEN_W'(rx_q);
        div_start = 1'b1;
        state_d   = S_DIV;
      end
      S_DIV: begin
        // Quotient never exceeds a1, so only its low A1_W bits are kept.
        if (div_done) begin
          a2_d    = div_quot;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a1_q    <= '0;
      rx_q    <= '0;
      num_q   <= '0;
      den_q   <= '0;
      a2_q    <= '0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      rx_q    <= rx_d;
      num_q   <= num_d;
      den_q   <= den_d;
      a2_q    <= a2_d;
    end
  end

  assign a2 = a2_q;

  seq_divider #(
    .NW(NUM_W),
    .DW(DEN_W),
    .QW(A1_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .start_i(div_start),
    .num_i  (num_q),
    .den_i  (den_q),
    .done_o (div_done),
    .quot_o (div_quot)
  );

endmodule

// File: tb/tb_res_to_code.sv
// Scoreboard bench for res_to_code: the driver pushes the expected code and
// acceptance edge for each request, the monitor pops on every done pulse.
module tb_res_to_code;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] a1;
  logic [10:0] rx;
  logic        busy;
  logic        done;
  logic [11:0] a2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_pushed = 0;
  int n_popped = 0;

  int exp_q[$];
  int edge_q[$];

  res_to_code dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a1   (a1),
    .rx   (rx),
    .busy (busy),
    .done (done),
    .a2   (a2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(int a, int r);
    longint p;
    p = longint'(a) * longint'(r);
    return int'(p / longint'(10000 + r));
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        int e;
        int n;
        e = exp_q.pop_front();
        n = edge_q.pop_front();
        n_popped++;
        chk("a2", int'(a2), e);
        chk("latency", cyc - n, 24);
        chk("busy_at_done", int'(busy), 1);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Leaves the bench at the negedge after the accepting edge N.
  task automatic issue(input int a, input int r, input bit expect_done);
    wait_idle();
    a1    = 12'(a);
    rx    = 11'(r);
    start = 1'b1;
    if (expect_done) begin
      exp_q.push_back(model(a, r));
      edge_q.push_back(cyc + 1);
      n_pushed++;
    end
    @(negedge clk);
    start = 1'b0;
    a1    = 12'($urandom);
    rx    = 11'($urandom);
  endtask

  initial begin
    int a;
    int r;
    int k;
    rst   = 1'b1;
    start = 1'b0;
    a1    = '0;
    rx    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_a2",   int'(a2),   0);
    rst   = 1'b0;

    // Directed cases with known answers.
    issue(4095, 10000 & 2047, 1);
    issue(4095, 2047, 1);
    issue(3000, 2047, 1);
    wait_idle();
    chk("ref_3000_2047", model(3000, 2047), 509);
    chk("ref_4095_2047", model(4095, 2047), 695);
    repeat (3) @(negedge clk);
    chk("a2_hold", int'(a2), 509);

    // rx = 0: full latency, busy high throughout.
    issue(1000, 0, 1);
    chk("busy_rx0", int'(busy), 1);
    repeat (24) begin
      @(negedge clk);
      chk("busy_rx0", int'(busy), 1);
    end
    @(negedge clk);
    chk("busy_rx0_end", int'(busy), 0);
    issue(0, 1234, 1);

    // Starts while busy (N+5, N+24) and in DONE (N+25) are ignored.
    issue(2000, 500, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; a1 = 12'd4095; rx = 11'd2047;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    start = 1'b1; a1 = 12'd1; rx = 11'd1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored", int'(busy), 0);

    // Reset at N+10 aborts without a done pulse.
    issue(3000, 1500, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_a2",   int'(a2),   0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    issue(3000, 1500, 1);

    // Random vectors with boundary values mixed in.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0: begin a = 4095; r = 2047; end
        1: begin a = 0;    r = int'($urandom_range(0, 2047)); end
        2: begin a = int'($urandom_range(0, 4095)); r = 0; end
        3: begin a = 4095; r = int'($urandom_range(0, 2047)); end
        default: begin
          a = int'($urandom_range(0, 4095));
          r = int'($urandom_range(0, 2047));
        end
      endcase
      issue(a, r, 1);
      if ($urandom_range(0, 3) == 0) begin
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("done_count", n_popped, n_pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
